// File: rtl/mux4_rr_arbiter.sv
// Four-requester arbiter driving a registered 4:1 byte mux, with a per-grant beat limit.
// Build option: define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             out_ready,
  output logic [3:0]       grant,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [7:0]       hold_cnt;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             found;
  logic [WIDTH-1:0] din_sel;

  // ptr is never advanced in fixed-priority builds, so scanning from ptr yields lowest-index-wins.
  always_comb begin
    winner = ptr;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    din_sel = '0;
    case (select)
      2'd0: din_sel = din0;
      2'd1: din_sel = din1;
      2'd2: din_sel = din2;
      2'd3: din_sel = din3;
      default: din_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      grant      <= '0;
      select     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dout_valid <= 1'b0;
          if (|req) begin
            grant    <= 4'b0001 << winner;
            select   <= winner;
            hold_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!req[select]) begin
            dout_valid <= 1'b0;
            grant      <= '0;
            state      <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
            ptr        <= select + 2'd1;
`endif
          end else if (out_ready) begin
            dout       <= din_sel;
            dout_valid <= 1'b1;
            hold_cnt   <= hold_cnt + 8'd1;
            // The beat that reaches the limit is still delivered before release.
            if (hold_cnt == HOLD_LAST) begin
              grant <= '0;
              state <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
              ptr   <= select + 2'd1;
`endif
            end
          end else begin
            dout_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed stimulus queues expected beats, a monitor checks them.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] dv [4];
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] select;
  logic [7:0] dout;
  logic       dout_valid;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
  } beat_t;

  beat_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .din0(dv[0]), .din1(dv[1]), .din2(dv[2]), .din3(dv[3]),
    .out_ready(out_ready), .grant(grant), .select(select),
    .dout(dout), .dout_valid(dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int o, input int n);
    beat_t b;
    b.data = dv[o];
    b.sel  = 2'(o);
    for (int i = 0; i < n; i++) sb.push_back(b);
  endtask

  // One full grant at out_ready=1: arbitration edge, four beats, release on the fourth.
  task automatic serve(input int o);
    logic [3:0] oh;
    oh = 4'b0001 << o;
    push_beats(o, 4);
    tick();
    check("serve_grant", 32'(grant), 32'(oh));
    check("serve_select", 32'(select), 32'(o));
    for (int b = 0; b < 4; b++) begin
      tick();
      check("serve_valid", 32'(dout_valid), 32'd1);
      check("serve_dout", 32'(dout), 32'(dv[o]));
      check("serve_grant_hold", 32'(grant), (b < 3) ? 32'(oh) : 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got beat %0h sel %0d expected no beat", dout, select);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if (dout !== e.data || select !== e.sel) begin
          n_bad++;
          $display("FAIL sb_beat: got %0h sel %0d expected %0h sel %0d", dout, select, e.data, e.sel);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int own3[4];
  int own5[2];
  logic ors[6];

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    own3 = '{0, 0, 0, 0};
    own5 = '{0, 0};
`else
    own3 = '{1, 2, 3, 0};
    own5 = '{0, 2};
`endif
    ors = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) dv[i] = '0;

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_valid", 32'(dout_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_select", 32'(select), 32'd0);
      check("idle_dout", 32'(dout), 32'd0);
      check("idle_valid", 32'(dout_valid), 32'd0);
    end

    // Single requester, drops after 3 beats
    req = 4'b0001; dv[0] = 8'hA5; out_ready = 1'b1;
    push_beats(0, 3);
    tick();
    check("single_grant", 32'(grant), 32'h1);
    check("single_valid0", 32'(dout_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_valid", 32'(dout_valid), 32'd1);
      check("single_grant_hold", 32'(grant), 32'h1);
    end
    req = 4'b0000;
    tick();
    check("single_release", 32'(grant), 32'd0);
    check("single_novalid", 32'(dout_valid), 32'd0);
    check("single_dout_hold", 32'(dout), 32'hA5);

    // Hold limit and rotation; the first owner also shows where ptr was left
    for (int i = 0; i < 4; i++) dv[i] = 8'(8'h10 + i);
    req = 4'b1111;
    for (int g = 0; g < 4; g++) serve(own3[g]);
    req = 4'b0000;

    // Backpressure on owner 2
    dv[2] = 8'h5C;
    req = 4'b0100;
    push_beats(2, 4);
    tick();
    check("bp_grant", 32'(grant), 32'h4);
    for (int i = 0; i < 6; i++) begin
      out_ready = ors[i];
      tick();
      check("bp_valid", 32'(dout_valid), 32'(ors[i]));
      check("bp_dout", 32'(dout), 32'h5C);
      check("bp_grant_hold", 32'(grant), (i < 5) ? 32'h4 : 32'd0);
    end
    req = 4'b0000;
    out_ready = 1'b1;

    // Wrap from ptr=3 past requester 1
    dv[0] = 8'h21;
    req = 4'b0101;
    serve(own5[0]);
    serve(own5[1]);
    req = 4'b0000;

    // Asynchronous reset during owner 1's second beat
    dv[1] = 8'h77;
    req = 4'b0010;
    push_beats(1, 1);
    tick();
    check("mid_grant", 32'(grant), 32'h2);
    tick();
    tick();
    check("mid_beat2", 32'(dout_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_dout", 32'(dout), 32'd0);
    check("async_valid", 32'(dout_valid), 32'd0);
    check("async_select", 32'(select), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_grant", 32'(grant), 32'h2);
    check("post_rst_select", 32'(select), 32'd1);
    req = 4'b0000;
    tick();
    check("post_rst_release", 32'(grant), 32'd0);
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
